// File: rtl/uart_tx_fifo_engine.sv
// UART transmit engine: DEPTH-entry byte FIFO feeding an 8N1 serialiser with an internal baud counter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo_engine #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 108
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       tx_wen,
  input  logic [7:0] uart_din,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int BW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity8(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0] count_r, count_s;
  logic          full_r, empty_r;
  logic          wr_en_s, pop_s;
  logic [7:0]    head_s;

  state_t        state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    idx_r, idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          bit_end_s;
  logic          tx_r, tx_s, busy_r;
`ifdef UART_TX_PARITY_EN
  logic          par_r, par_s;
`endif

  // A full FIFO rejects writes even when a pop happens in the same cycle.
  assign wr_en_s   = tx_wen && !full_r;
  assign head_s    = mem_r[rd_ptr_r];
  assign bit_end_s = (baud_r == BW'(CLKS_PER_BIT - 1));

  // Occupancy update from accepted writes and FSM pops.
  always_comb begin
    count_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_s = count_r + CNTW'(1);
      2'b01:   count_s = count_r - CNTW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= uart_din;
    end
  end

  // FIFO pointers, count and registered flags.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNTW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r  <= count_s;
      full_r   <= (count_s == CNTW'(DEPTH));
      empty_r  <= (count_s == {CNTW{1'b0}});
    end
  end

  // Frame sequencing: next state, baud counter, bit index, shift register and FIFO pop.
  always_comb begin
    state_s = state_r;
    baud_s  = bit_end_s ? {BW{1'b0}} : baud_r + BW'(1);
    idx_s   = idx_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        baud_s = {BW{1'b0}};
        if (!empty_r) begin
          pop_s   = 1'b1;
          shift_s = head_s;
`ifdef UART_TX_PARITY_EN
          par_s   = even_parity8(head_s);
`endif
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          idx_s   = 3'd0;
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[7:1]};
          idx_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more bytes are waiting.
        if (bit_end_s && !empty_r) begin
          pop_s   = 1'b1;
          shift_s = head_s;
`ifdef UART_TX_PARITY_EN
          par_s   = even_parity8(head_s);
`endif
          state_s = START;
        end else if (bit_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = {BW{1'b0}};
      end
    endcase
  end

  // Line level for the bit currently being sent.
  always_comb begin
    tx_s = 1'b1;
    case (state_r)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = par_r;
`endif
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // FSM registers plus the registered serial line and busy flag.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_r <= IDLE;
      baud_r  <= {BW{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE);
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign tx_full  = full_r;
  assign tx_empty = empty_r;
  assign tx_busy  = busy_r;
  assign tx       = tx_r;

endmodule
